// File: rtl/shft_ctrl.sv
// Round-robin two-requester sequencer driving shft_mod load/dir/LD; optional cout capture (SHFT_CTRL_CAPTURE_EN).
// Latency: grant+load 1 cycle after request, done SHIFTS+1 cycles after load, job period SHIFTS+2.
// Backpressure: requests are level-held and wait while a job is in flight; no internal queueing.
module shft_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SHIFTS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req_i,
    input  logic [1:0]       dir_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic [1:0]       gnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic             load,
    output logic             dir,
    output logic [WIDTH-1:0] LD
`ifdef SHFT_CTRL_CAPTURE_EN
    ,
    input  logic             cout,
    output logic [WIDTH-1:0] cap_o
`endif
);

    localparam int CW = $clog2(SHIFTS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          arb_vld;
    logic          win;

    // Contested: the requester that did not win last time goes next.
    always_comb begin
        arb_vld = |req_i;
        win     = 1'b0;
        if (req_i == 2'b11) begin
            win = ~last;
        end else begin
            win = req_i[1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            gnt_o     <= 2'b00;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            done_id_o <= 1'b0;
            load      <= 1'b0;
            dir       <= 1'b1;
            LD        <= '0;
`ifdef SHFT_CTRL_CAPTURE_EN
            cap_o     <= '0;
`endif
        end else begin
            case (state)
                // The DONE exit edge doubles as the IDLE sampling edge, so
                // back-to-back jobs run every SHIFTS+2 cycles.
                S_IDLE, S_DONE: begin
                    done_o <= 1'b0;
                    if (arb_vld) begin
                        gnt_o  <= win ? 2'b10 : 2'b01;
                        LD     <= win ? data1_i : data0_i;
                        dir    <= dir_i[win];
                        load   <= 1'b1;
                        busy_o <= 1'b1;
                        last   <= win;
                        state  <= S_LOAD;
`ifdef SHFT_CTRL_CAPTURE_EN
                        cap_o  <= '0;
`endif
                    end else begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    load  <= 1'b0;
                    gnt_o <= 2'b00;
                    cnt   <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    cnt <= cnt + CW'(1);
`ifdef SHFT_CTRL_CAPTURE_EN
                    cap_o <= {cap_o[WIDTH-2:0], cout};
`endif
                    if (cnt == CW'(SHIFTS - 1)) begin
                        state     <= S_DONE;
                        done_o    <= 1'b1;
                        done_id_o <= last;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shft_ctrl.sv
// Scoreboard bench for shft_ctrl: one instance at SHIFTS=8, one at SHIFTS=1.
module tb_shft_ctrl;

    typedef struct {
        bit         dn;
        logic [1:0] g;
        bit         id;
        logic [7:0] ld;
        bit         dr;
        int         gap;
        logic [7:0] cap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] req_a, req_b, dir_i;
    logic [7:0] d0, d1;
    logic [1:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, done_a, done_b, did_a, did_b, load_a, load_b, dir_a, dir_b;
    logic [7:0] ld_a, ld_b;
    logic [7:0] cap_a = 8'h00;
    logic [7:0] cap_b = 8'h00;
`ifdef SHFT_CTRL_CAPTURE_EN
    logic       cout_a, cout_b;
    localparam logic [7:0] CAP_JOB1 = 8'hAA;
`else
    localparam logic [7:0] CAP_JOB1 = 8'h00;
`endif

    exp_t q0[$];
    exp_t q1[$];
    bit   pg[2];
    int   lastc[2];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shft_ctrl #(.WIDTH(8), .SHIFTS(8)) dut_a (
        .clk(clk), .rstn(rstn), .req_i(req_a), .dir_i(dir_i),
        .data0_i(d0), .data1_i(d1), .gnt_o(gnt_a), .busy_o(busy_a),
        .done_o(done_a), .done_id_o(did_a), .load(load_a), .dir(dir_a), .LD(ld_a)
`ifdef SHFT_CTRL_CAPTURE_EN
        , .cout(cout_a), .cap_o(cap_a)
`endif
    );

    shft_ctrl #(.WIDTH(8), .SHIFTS(1)) dut_b (
        .clk(clk), .rstn(rstn), .req_i(req_b), .dir_i(dir_i),
        .data0_i(d0), .data1_i(d1), .gnt_o(gnt_b), .busy_o(busy_b),
        .done_o(done_b), .done_id_o(did_b), .load(load_b), .dir(dir_b), .LD(ld_b)
`ifdef SHFT_CTRL_CAPTURE_EN
        , .cout(cout_b), .cap_o(cap_b)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic exp_g(input int u, input logic [1:0] g, input logic [7:0] ld, input bit dr, input int gap);
        exp_t e;
        e = '{dn: 1'b0, g: g, id: 1'b0, ld: ld, dr: dr, gap: gap, cap: 8'h00};
        push(u, e);
    endtask

    task automatic exp_d(input int u, input bit id, input int gap, input logic [7:0] cap);
        exp_t e;
        e = '{dn: 1'b1, g: 2'b00, id: id, ld: 8'h00, dr: 1'b0, gap: gap, cap: cap};
        push(u, e);
    endtask

    task automatic mon(input int u, input logic [1:0] g, input logic ld, input logic [7:0] lv,
                       input logic dr, input logic bsy, input logic dn, input logic did,
                       input logic [7:0] cp);
        exp_t e;
        int   qs;
        if (pg[u]) begin
            chk("load_one_cycle", {31'd0, ld}, 0);
            chk("gnt_one_cycle", {30'd0, g}, 0);
        end
        pg[u] = (g != 2'b00);
        if (g != 2'b00 || dn) begin
            qs = (u == 0) ? q0.size() : q1.size();
            nvec++;
            if (qs == 0) begin
                nerr++;
                $display("FAIL unexpected_event dut%0d: gnt=%b done=%b, nothing expected", u, g, dn);
            end else begin
                if (u == 0) e = q0.pop_front();
                else e = q1.pop_front();
                if (e.dn) begin
                    chk("done_pulse", {31'd0, dn}, 1);
                    chk("done_id", {31'd0, did}, {31'd0, e.id});
`ifdef SHFT_CTRL_CAPTURE_EN
                    chk("cap_o", {24'd0, cp}, {24'd0, e.cap});
`endif
                end else begin
                    chk("gnt", {30'd0, g}, {30'd0, e.g});
                    chk("load", {31'd0, ld}, 1);
                    chk("LD", {24'd0, lv}, {24'd0, e.ld});
                    chk("dir", {31'd0, dr}, {31'd0, e.dr});
                    chk("busy", {31'd0, bsy}, 1);
                end
                if (e.gap > 0) chk("event_gap", cyc - lastc[u], e.gap);
            end
            lastc[u] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            pg[0] = 1'b0;
            pg[1] = 1'b0;
        end else begin
            mon(0, gnt_a, load_a, ld_a, dir_a, busy_a, done_a, did_a, cap_a);
            mon(1, gnt_b, load_b, ld_b, dir_b, busy_b, done_b, did_b, cap_b);
        end
    end

    task automatic wait_gnt(input int u);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (u == 0) ? (gnt_a != 2'b00) : (gnt_b != 2'b00);
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL gnt_timeout dut%0d: no grant within 40 cycles", u);
        end
    endtask

    task automatic wait_idle(input int u);
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = (u == 0) ? !busy_a : !busy_b;
        end
        if (!idle) begin
            nvec++;
            nerr++;
            $display("FAIL idle_timeout dut%0d: busy still high after 40 cycles", u);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_gnt"}, {30'd0, gnt_a}, 0);
        chk({tag, "_load"}, {31'd0, load_a}, 0);
        chk({tag, "_dir"}, {31'd0, dir_a}, 1);
        chk({tag, "_LD"}, {24'd0, ld_a}, 0);
        chk({tag, "_busy"}, {31'd0, busy_a}, 0);
        chk({tag, "_done"}, {31'd0, done_a}, 0);
        chk({tag, "_done_id"}, {31'd0, did_a}, 0);
`ifdef SHFT_CTRL_CAPTURE_EN
        chk({tag, "_cap"}, {24'd0, cap_a}, 0);
`endif
    endtask

    initial begin
        rstn = 1'b0; req_a = 2'b00; req_b = 2'b00; dir_i = 2'b00; d0 = 8'h00; d1 = 8'h00;
`ifdef SHFT_CTRL_CAPTURE_EN
        cout_a = 1'b0; cout_b = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_reset_a("rst");
        rstn = 1'b1;

        // Single job from requester 0, left shift.
        @(negedge clk);
        d0 = 8'h56; dir_i = 2'b10; req_a = 2'b01;
        exp_g(0, 2'b01, 8'h56, 1'b0, 0);
        exp_d(0, 1'b0, 9, CAP_JOB1);
        wait_gnt(0);
        req_a = 2'b00;
`ifdef SHFT_CTRL_CAPTURE_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cout_a = (i % 2 == 0);
        end
`endif
        wait_idle(0);

        // Contention: last=0 after the single job, so requester 1 leads.
        d0 = 8'hA5; d1 = 8'h3C; dir_i = 2'b01; req_a = 2'b11;
        exp_g(0, 2'b10, 8'h3C, 1'b0, 0); exp_d(0, 1'b1, 9, 8'h00);
        exp_g(0, 2'b01, 8'hA5, 1'b1, 1); exp_d(0, 1'b0, 9, 8'h00);
        exp_g(0, 2'b10, 8'h3C, 1'b0, 1); exp_d(0, 1'b1, 9, 8'h00);
        exp_g(0, 2'b01, 8'hA5, 1'b1, 1); exp_d(0, 1'b0, 9, 8'h00);
        for (int k = 0; k < 4; k++) wait_gnt(0);
        req_a = 2'b00;
        wait_idle(0);

        // Busy masking: requester 1 arrives mid-shift and waits for the DONE exit edge.
        d0 = 8'h81; d1 = 8'hC3; dir_i = 2'b01; req_a = 2'b01;
        exp_g(0, 2'b01, 8'h81, 1'b1, 0); exp_d(0, 1'b0, 9, 8'h00);
        exp_g(0, 2'b10, 8'hC3, 1'b0, 1); exp_d(0, 1'b1, 9, 8'h00);
        wait_gnt(0);
        req_a = 2'b00;
        repeat (4) @(negedge clk);
        req_a = 2'b10;
        wait_gnt(0);
        req_a = 2'b00;
        wait_idle(0);

        // Reset mid-shift: outputs clear asynchronously and no done follows.
        d0 = 8'h5A; dir_i = 2'b00; req_a = 2'b01;
        exp_g(0, 2'b01, 8'h5A, 1'b0, 0);
        wait_gnt(0);
        req_a = 2'b00;
        repeat (4) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_reset_a("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy_a}, 0);

        // last returns to 1 on reset, so requester 0 wins the contest.
        d0 = 8'h11; d1 = 8'h22; dir_i = 2'b11; req_a = 2'b11;
        exp_g(0, 2'b01, 8'h11, 1'b1, 0); exp_d(0, 1'b0, 9, 8'h00);
        wait_gnt(0);
        req_a = 2'b00;
        wait_idle(0);

        // SHIFTS=1 instance: done 2 cycles after load, period 3.
        d0 = 8'h77; d1 = 8'h88; dir_i = 2'b01; req_b = 2'b11;
        exp_g(1, 2'b01, 8'h77, 1'b1, 0); exp_d(1, 1'b0, 2, 8'h00);
        exp_g(1, 2'b10, 8'h88, 1'b0, 1); exp_d(1, 1'b1, 2, 8'h00);
        wait_gnt(1);
        wait_gnt(1);
        req_b = 2'b00;
        wait_idle(1);
        repeat (3) @(negedge clk);

        chk("queue_a_drained", q0.size(), 0);
        chk("queue_b_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
